// File: rtl/sc_datamem_mmio_if.sv
// CPU-side data bus of the data-memory / MMIO block: address, store data and strobe in;
// combinational read data, debug taps and the registered misalignment flag out.
interface sc_datamem_mmio_if;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        we;
  logic [1:0]  size;
  logic [31:0] dataout;
  logic [31:0] mem_dataout;
  logic [31:0] io_read_data;
  logic        align_err;

  modport master (
    output addr, datain, we, size,
    input  dataout, mem_dataout, io_read_data, align_err
  );

  modport slave (
    input  addr, datain, we, size,
    output dataout, mem_dataout, io_read_data, align_err
  );
endinterface

// File: rtl/sc_datamem_mmio.sv
// Word RAM plus memory-mapped I/O register file (output ports, synchronised inputs,
// sticky change flags, cycle counter) with byte/half/word stores and misalignment detection.
module sc_datamem_mmio #(
  parameter int DEPTH  = 32,
  parameter int IO_BIT = 7,
  parameter int N_OUT  = 3,
  parameter int N_IN   = 2,
  parameter int IN_W   = 5,
  parameter int LED_W  = 10
) (
  input  logic                   clock,
  input  logic                   resetn,
  sc_datamem_mmio_if.slave       bus,
  input  logic [N_IN*IN_W-1:0]   in_port,
  output logic [N_OUT*32-1:0]    out_port,
  output logic [LED_W-1:0]       led
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [4:0] R_FLAGS = 5'd16;
  localparam logic [4:0] R_CNT   = 5'd17;

  logic [31:0]             mem [DEPTH];
  logic [AW-1:0]           ram_idx;
  logic [4:0]              io_r;
  logic                    io_sel;
  logic                    misal;
  logic                    wr_en;
  logic                    wr_io;
  logic                    wr_ram;
  logic [3:0]              be;
  logic [31:0]             wdata;
  logic [31:0]             clr_word;
  logic [31:0]             io_rdata;
  logic [N_OUT-1:0][31:0]  out_q, out_d;
  logic [N_IN*IN_W-1:0]    s1_q, s2_q, prev_q;
  logic [N_IN-1:0]         flag_q, flag_d, flag_set, flag_clr;
  logic [31:0]             cnt_q, cnt_d;
  logic                    aerr_q;
  logic                    unused_addr;

  function automatic logic [31:0] lane_merge(logic [31:0] old, logic [31:0] nw, logic [3:0] en);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++)
      if (en[b]) res[b*8 +: 8] = nw[b*8 +: 8];
    return res;
  endfunction

  assign io_sel      = bus.addr[IO_BIT];
  assign ram_idx     = bus.addr[AW+1:2];
  assign io_r        = bus.addr[6:2];
  assign unused_addr = ^bus.addr;

  // Replicate the right-aligned store data onto every lane; the enables pick the lanes.
  always_comb begin
    be    = 4'b1111;
    wdata = bus.datain;
    misal = 1'b0;
    case (bus.size)
      2'b00: begin
        be    = 4'b0001 << bus.addr[1:0];
        wdata = {4{bus.datain[7:0]}};
      end
      2'b01: begin
        be    = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.datain[15:0]}};
        misal = bus.addr[0];
      end
      default: misal = |bus.addr[1:0];
    endcase
  end

  assign wr_en  = bus.we & ~misal;
  assign wr_io  = wr_en & io_sel;
  assign wr_ram = wr_en & ~io_sel;

  always_comb begin
    clr_word = '0;
    if (wr_io && io_r == R_FLAGS) clr_word = lane_merge('0, wdata, be);
    flag_clr = clr_word[N_IN-1:0];
    for (int k = 0; k < N_IN; k++)
      flag_set[k] = s2_q[k*IN_W +: IN_W] != prev_q[k*IN_W +: IN_W];
    // A new event on the same edge as its clear must survive, so set is applied last.
    flag_d = (flag_q & ~flag_clr) | flag_set;
    cnt_d  = (wr_io && io_r == R_CNT) ? '0 : cnt_q + 32'd1;
    for (int k = 0; k < N_OUT; k++)
      out_d[k] = (wr_io && io_r == 5'(k)) ? lane_merge(out_q[k], wdata, be) : out_q[k];
  end

  always_comb begin
    io_rdata = '0;
    for (int k = 0; k < N_OUT; k++)
      if (io_r == 5'(k)) io_rdata = out_q[k];
    for (int k = 0; k < N_IN; k++)
      if (io_r == 5'(8 + k)) io_rdata = 32'(s2_q[k*IN_W +: IN_W]);
    if (io_r == R_FLAGS) io_rdata = 32'(flag_q);
    if (io_r == R_CNT)   io_rdata = cnt_q;
  end

  always_ff @(posedge clock) begin
    if (wr_ram) mem[ram_idx] <= lane_merge(mem[ram_idx], wdata, be);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_q  <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      flag_q <= '0;
      cnt_q  <= '0;
      aerr_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      s1_q   <= in_port;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
      aerr_q <= bus.we & misal;
    end
  end

  assign out_port         = out_q;
  assign led              = out_q[0][LED_W-1:0];
  assign bus.mem_dataout  = mem[ram_idx];
  assign bus.io_read_data = io_rdata;
  assign bus.dataout      = io_sel ? io_rdata : mem[ram_idx];
  assign bus.align_err    = aerr_q;

endmodule

// File: tb/tb_sc_datamem_mmio.sv
// Randomised and directed bench for sc_datamem_mmio against a byte-address-level reference model.
module tb_sc_datamem_mmio;
  localparam int DEPTH = 32, IO_BIT = 7, N_OUT = 3, N_IN = 2, IN_W = 5, LED_W = 10;
  localparam int AW = $clog2(DEPTH);
  localparam int IW = N_IN * IN_W;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic [IW-1:0]     in_port = '0;
  logic [N_OUT*32-1:0] out_port;
  logic [LED_W-1:0]  led;

  sc_datamem_mmio_if bus();

  sc_datamem_mmio #(.DEPTH(DEPTH), .IO_BIT(IO_BIT), .N_OUT(N_OUT), .N_IN(N_IN),
                    .IN_W(IN_W), .LED_W(LED_W)) dut (
    .clock(clock), .resetn(resetn), .bus(bus), .in_port(in_port),
    .out_port(out_port), .led(led)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0]   m_ram [DEPTH];
  logic [31:0]   m_out [N_OUT];
  logic [IW-1:0] hist[$];
  logic [31:0]   m_flags;
  logic [31:0]   m_cnt;
  logic          m_aerr;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_misal(input logic [31:0] a, input logic [1:0] sz);
    return (int'(a[1:0]) % nbytes(sz)) != 0;
  endfunction

  // Bytes [a, a+n) of the addressed word receive the low n bytes of the store data.
  function automatic logic [31:0] store_into(input logic [31:0] old, input logic [31:0] a,
                                             input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] res;
    int n, start;
    res = old;
    n = nbytes(sz);
    start = int'(a[1:0]);
    for (int i = 0; i < n; i++) res[(start + i) * 8 +: 8] = d[i * 8 +: 8];
    return res;
  endfunction

  function automatic logic [IW-1:0] synced();
    return hist[hist.size() - 2];
  endfunction

  function automatic logic [31:0] m_io(input logic [31:0] a);
    int r;
    logic [IW-1:0] s;
    r = int'(a[6:2]);
    s = synced();
    if (r < N_OUT) return m_out[r];
    if (r >= 8 && r < 8 + N_IN) return 32'(s[(r - 8) * IN_W +: IN_W]);
    if (r == 16) return m_flags;
    if (r == 17) return m_cnt;
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    return a[IO_BIT] ? m_io(a) : m_ram[a[AW+1:2]];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N_OUT; k++) m_out[k] = '0;
    hist.delete();
    repeat (3) hist.push_back('0);
    m_flags = '0;
    m_cnt   = '0;
    m_aerr  = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] a, d;
    logic [1:0] sz;
    logic [IW-1:0] cur, old;
    bit ok;
    int r;
    a = bus.addr; d = bus.datain; sz = bus.size;
    ok = bus.we && !is_misal(a, sz);
    r = int'(a[6:2]);
    cur = hist[hist.size() - 2];
    old = hist[hist.size() - 3];
    if (ok && a[IO_BIT] && r == 16) m_flags = m_flags & ~store_into('0, a, sz, d);
    for (int k = 0; k < N_IN; k++)
      if (cur[k * IN_W +: IN_W] != old[k * IN_W +: IN_W]) m_flags[k] = 1'b1;
    if (ok && a[IO_BIT] && r == 17) m_cnt = '0;
    else m_cnt = m_cnt + 1;
    if (ok && a[IO_BIT] && r < N_OUT) m_out[r] = store_into(m_out[r], a, sz, d);
    if (ok && !a[IO_BIT]) m_ram[a[AW+1:2]] = store_into(m_ram[a[AW+1:2]], a, sz, d);
    hist.push_back(in_port);
    if (hist.size() > 3) void'(hist.pop_front());
    m_aerr = bus.we && is_misal(a, sz);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [1:0] sz);
    bus.addr = a; bus.datain = d; bus.we = w; bus.size = sz;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    drive(a, 32'd0, 1'b0, 2'd2);
    #1;
    check(tag, bus.dataout, exp);
  endtask

  task automatic check_outs(input string tag);
    for (int k = 0; k < N_OUT; k++)
      check($sformatf("%s out%0d", tag, k), out_port[k*32 +: 32], m_out[k]);
    check({tag, " led"}, 32'(led), 32'(m_out[0][LED_W-1:0]));
    check({tag, " align_err"}, 32'(bus.align_err), 32'(m_aerr));
  endtask

  initial begin
    logic [31:0] a, d;
    logic [1:0] sz;
    logic w;
    int pick;
    drive(32'd0, 32'd0, 1'b0, 2'd2);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset out0", out_port[31:0], 32'd0);
    check("reset led", 32'(led), 32'd0);
    check("reset align_err", 32'(bus.align_err), 32'd0);
    rd("reset counter", 32'hC4, 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      drive(i * 4, $urandom, 1'b1, 2'd2);
      tick();
    end

    drive(32'h04, 32'h12345678, 1'b1, 2'd2); tick();
    rd("word rd", 32'h04, 32'h12345678);
    check("word mem_dataout", bus.mem_dataout, 32'h12345678);
    drive(32'h06, 32'h000000AB, 1'b1, 2'd0); tick();
    rd("byte wr", 32'h04, 32'h12AB5678);
    drive(32'h04, 32'h0000BEEF, 1'b1, 2'd1); tick();
    rd("half wr", 32'h04, 32'h12ABBEEF);

    drive(32'h05, 32'hDEADBEEF, 1'b1, 2'd2); tick();
    check("misal word aerr", 32'(bus.align_err), 32'd1);
    rd("misal word ram", 32'h04, 32'h12ABBEEF);
    tick();
    check("misal aerr drop", 32'(bus.align_err), 32'd0);
    drive(32'h07, 32'h00001111, 1'b1, 2'd1); tick();
    check("misal half aerr", 32'(bus.align_err), 32'd1);
    rd("misal half ram", 32'h04, 32'h12ABBEEF);
    tick();
    check("misal half drop", 32'(bus.align_err), 32'd0);

    drive(32'h80, 32'h000003FF, 1'b1, 2'd2); tick();
    check("out0 wr", out_port[31:0], 32'h3FF);
    check("led wr", 32'(led), 32'h3FF);
    rd("out0 rd", 32'h80, 32'h3FF);
    check("out0 io_read_data", bus.io_read_data, 32'h3FF);
    #2 resetn = 1'b0;
    #1;
    check("async rst out0", out_port[31:0], 32'd0);
    check("async rst led", 32'(led), 32'd0);
    model_reset();
    @(posedge clock);
    #1 resetn = 1'b1;
    rd("ram kept", 32'h04, 32'h12ABBEEF);

    in_port = 10'h015;
    drive(32'hA0, 32'd0, 1'b0, 2'd2);
    tick(); rd("in0 edge1", 32'hA0, 32'd0);
    tick(); rd("in0 edge2", 32'hA0, 32'h15);
    rd("flag edge2", 32'hC0, 32'd0);
    tick(); rd("flag edge3", 32'hC0, 32'd1);
    drive(32'hC0, 32'd1, 1'b1, 2'd2); tick();
    rd("flag w1c", 32'hC0, 32'd0);
    in_port = 10'h00A;
    tick(); tick();
    drive(32'hC0, 32'd1, 1'b1, 2'd2); tick();
    rd("flag set wins", 32'hC0, 32'd1);

    rd("cnt a", 32'hC4, m_cnt);
    tick(); rd("cnt b", 32'hC4, m_cnt);
    drive(32'hC4, 32'h55, 1'b1, 2'd2); tick();
    rd("cnt clr", 32'hC4, 32'd0);
    tick(); rd("cnt after clr", 32'hC4, 32'd1);
    force dut.cnt_q = 32'hFFFFFFFF;
    #1 release dut.cnt_q;
    m_cnt = 32'hFFFFFFFF;
    rd("cnt max", 32'hC4, 32'hFFFFFFFF);
    tick(); rd("cnt wrap", 32'hC4, 32'd0);

    for (int it = 0; it < 400; it++) begin
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 1) begin
        a[IO_BIT] = 1'b1;
        pick = $urandom_range(0, 9);
        case (pick)
          0, 1, 2, 3: a[6:2] = 5'(pick);
          4, 5, 6:    a[6:2] = 5'(pick + 4);
          7:          a[6:2] = 5'd16;
          8:          a[6:2] = ($urandom_range(0, 3) == 0) ? 5'd17 : 5'd16;
          default:    a[6:2] = 5'($urandom_range(0, 31));
        endcase
      end else begin
        a[IO_BIT] = 1'b0;
      end
      d  = $urandom;
      sz = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) in_port = IW'($urandom);
      drive(a, d, w, sz);
      #1;
      check($sformatf("rnd%0d dataout", it), bus.dataout, m_read(a));
      check($sformatf("rnd%0d mem", it), bus.mem_dataout, m_ram[a[AW+1:2]]);
      check($sformatf("rnd%0d io", it), bus.io_read_data, m_io(a));
      tick();
      check_outs($sformatf("rnd%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "timeout");
  end
endmodule
